// File: rtl/edge_threshold_stats.sv
`timescale 1ns/1ps
// edge_threshold_stats
// Thresholds the 12-bit Sobel edge magnitude into a binary edge map or passes
// it through, counts edge pixels per frame and reports the count once per
// frame on the frame-valid falling edge.
// Optional feature: define EDGE_PEAK_EN to add oEdgePeak, the largest
// in-frame magnitude of the last completed frame.
module edge_threshold_stats #(
  parameter int unsigned CNT_W = 22
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [11:0]      iDATA,
  input  logic             iDVAL,
  input  logic             iFVAL,
  input  logic [11:0]      iThreshold,
  input  logic             iBinarize,
  output logic [11:0]      oRed,
  output logic [11:0]      oGreen,
  output logic [11:0]      oBlue,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oEdgeCount,
  output logic             oCountValid,
  output logic             oBusy
`ifdef EDGE_PEAK_EN
  ,
  output logic [11:0]      oEdgePeak
`endif
);

  localparam int unsigned PIX_W = 12;
  localparam logic [PIX_W-1:0] PIX_ON  = '1;
  localparam logic [PIX_W-1:0] PIX_OFF = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IN_FRAME   = 2'd1,
    REPORT     = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;

  logic             fval_q;
  logic             armed_q;
  logic [PIX_W-1:0] thr_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] edge_count_q;
  logic             count_valid_q;
  logic             busy_q;
  logic [PIX_W-1:0] pix_q;
  logic             dval_q;

  logic             fval_rise;
  logic             fval_fall;
  logic             start_frame;
  logic             load_report;
  logic             count_en;
  logic [PIX_W-1:0] thr_live;
  logic             edge_hit;
  logic             pix_hit;

  // A rising edge only counts once iFVAL has been seen low after reset, so a
  // frame already in progress at reset release is skipped.
  assign fval_rise = iFVAL & ~fval_q & armed_q;
  assign fval_fall = ~iFVAL & fval_q;

  assign edge_hit = (iDATA >= thr_q);
  assign pix_hit  = (iDATA >= thr_live);

  // Frame-valid history and arming after reset.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fval_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      fval_q  <= iFVAL;
      armed_q <= armed_q | ~iFVAL;
    end
  end

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= WAIT_FRAME;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; REPORT may go straight back to IN_FRAME so a one-cycle
  // frame gap does not lose the following frame.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_FRAME: if (fval_rise) next_state = IN_FRAME;
      IN_FRAME:   if (fval_fall) next_state = REPORT;
      REPORT:     next_state = fval_rise ? IN_FRAME : WAIT_FRAME;
      default:    next_state = WAIT_FRAME;
    endcase
  end

  // FSM control decode: frame start, in-frame counting, report load, live threshold.
  always_comb begin
    start_frame = 1'b0;
    load_report = 1'b0;
    count_en    = 1'b0;
    thr_live    = iThreshold;
    case (state)
      WAIT_FRAME: start_frame = fval_rise;
      IN_FRAME: begin
        count_en    = iDVAL & iFVAL;
        load_report = fval_fall;
        thr_live    = thr_q;
      end
      REPORT:     start_frame = fval_rise;
      default:    start_frame = 1'b0;
    endcase
  end

  // Threshold is frozen for the whole frame at frame start.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      thr_q <= PIX_OFF;
    end else if (start_frame) begin
      thr_q <= iThreshold;
    end
  end

  // Saturating edge-pixel accumulator.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      acc_q <= '0;
    end else if (start_frame) begin
      acc_q <= '0;
    end else if (count_en && edge_hit && (acc_q != CNT_MAX)) begin
      acc_q <= acc_q + CNT_W'(1);
    end
  end

  // Report registers: count, one-cycle valid pulse and busy flag.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (load_report) begin
        edge_count_q <= acc_q;
      end
      count_valid_q <= load_report;
      busy_q        <= (next_state == IN_FRAME);
    end
  end

  // Pixel path: one-cycle registered binarize or pass-through.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pix_q  <= PIX_OFF;
      dval_q <= 1'b0;
    end else begin
      if (iBinarize) begin
        pix_q <= pix_hit ? PIX_ON : PIX_OFF;
      end else begin
        pix_q <= iDATA;
      end
      dval_q <= iDVAL;
    end
  end

`ifdef EDGE_PEAK_EN
  logic [PIX_W-1:0] peak_acc_q;
  logic [PIX_W-1:0] peak_q;

  // Running in-frame maximum, latched alongside the edge count.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      peak_acc_q <= PIX_OFF;
      peak_q     <= PIX_OFF;
    end else begin
      if (start_frame) begin
        peak_acc_q <= PIX_OFF;
      end else if (count_en && (iDATA > peak_acc_q)) begin
        peak_acc_q <= iDATA;
      end
      if (load_report) begin
        peak_q <= peak_acc_q;
      end
    end
  end

  assign oEdgePeak = peak_q;
`endif

  assign oRed        = pix_q;
  assign oGreen      = pix_q;
  assign oBlue       = pix_q;
  assign oDVAL       = dval_q;
  assign oEdgeCount  = edge_count_q;
  assign oCountValid = count_valid_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_edge_threshold_stats.sv
`timescale 1ns/1ps
// Directed bench for edge_threshold_stats: a 22-bit instance and a 4-bit
// instance share stimulus so counter saturation is visible on the small one.
module tb_edge_threshold_stats;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data;
  logic        dval;
  logic        fval;
  logic [11:0] thr;
  logic        binarize;

  logic [11:0] red, green, blue;
  logic        odval;
  logic [21:0] edge_count;
  logic        count_valid;
  logic        busy;

  logic [11:0] s_red, s_green, s_blue;
  logic        s_odval;
  logic [3:0]  s_edge_count;
  logic        s_count_valid;
  logic        s_busy;

`ifdef EDGE_PEAK_EN
  logic [11:0] peak;
  logic [11:0] s_peak;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] pix_buf [0:31];
  logic [11:0] exp_buf [0:31];

  always #5 clk = ~clk;

  edge_threshold_stats #(.CNT_W(22)) u_dut (
    .iCLK(clk), .iRST(rst_n), .iDATA(data), .iDVAL(dval), .iFVAL(fval),
    .iThreshold(thr), .iBinarize(binarize),
    .oRed(red), .oGreen(green), .oBlue(blue), .oDVAL(odval),
    .oEdgeCount(edge_count), .oCountValid(count_valid), .oBusy(busy)
`ifdef EDGE_PEAK_EN
    , .oEdgePeak(peak)
`endif
  );

  edge_threshold_stats #(.CNT_W(4)) u_sat (
    .iCLK(clk), .iRST(rst_n), .iDATA(data), .iDVAL(dval), .iFVAL(fval),
    .iThreshold(thr), .iBinarize(binarize),
    .oRed(s_red), .oGreen(s_green), .oBlue(s_blue), .oDVAL(s_odval),
    .oEdgeCount(s_edge_count), .oCountValid(s_count_valid), .oBusy(s_busy)
`ifdef EDGE_PEAK_EN
    , .oEdgePeak(s_peak)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Idle with frame-valid low; no pulse and the last count must hold.
  task automatic idle_check(input int n, input int hold_cnt);
    for (int i = 0; i < n; i++) begin
      fval = 1'b0; dval = 1'b0; data = 12'h000;
      cycle();
      check_eq("idle_cv", 32'(count_valid), 0);
      check_eq("idle_hold", 32'(edge_count), 32'(hold_cnt));
      check_eq("idle_busy", 32'(busy), 0);
    end
  endtask

  // One frame: rise cycle, n pixels from pix_buf, then the falling-edge cycle
  // (which carries an 0xFFF pixel when fall_dval=1 that must not be counted).
  task automatic send_frame(input int n, input int exp_cnt, input bit fall_dval,
                            input int chg_idx, input logic [11:0] chg_thr);
    int          exp_sat;
    logic [11:0] exp_pk;
    exp_sat = (exp_cnt > 15) ? 15 : exp_cnt;
    exp_pk  = 12'h000;
    fval = 1'b1; dval = 1'b0; data = 12'h000;
    cycle();
    check_eq("rise_cv", 32'(count_valid), 0);
    check_eq("rise_busy", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      if (i == chg_idx) thr = chg_thr;
      dval = 1'b1; data = pix_buf[i];
      if (pix_buf[i] > exp_pk) exp_pk = pix_buf[i];
      cycle();
      check_eq("pix_dval", 32'(odval), 1);
      check_eq("pix_red", 32'(red), 32'(exp_buf[i]));
      check_eq("pix_green", 32'(green), 32'(exp_buf[i]));
      check_eq("pix_blue", 32'(blue), 32'(exp_buf[i]));
      check_eq("pix_cv", 32'(count_valid), 0);
    end
    fval = 1'b0; dval = fall_dval; data = 12'hFFF;
    cycle();
    check_eq("rep_cv", 32'(count_valid), 1);
    check_eq("rep_count", 32'(edge_count), 32'(exp_cnt));
    check_eq("rep_sat_count", 32'(s_edge_count), 32'(exp_sat));
    check_eq("rep_busy", 32'(busy), 0);
    check_eq("rep_dval", 32'(odval), 32'(fall_dval));
`ifdef EDGE_PEAK_EN
    check_eq("rep_peak", 32'(peak), 32'(exp_pk));
`endif
    dval = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fval = 1'b1; dval = 1'b0; data = 12'h000;
    thr = 12'h400; binarize = 1'b0;

    // Reset values
    #3;
    check_eq("rst_red", 32'(red), 0);
    check_eq("rst_dval", 32'(odval), 0);
    check_eq("rst_count", 32'(edge_count), 0);
    check_eq("rst_cv", 32'(count_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    cycle();
    rst_n = 1'b1;

    // Frame in progress at reset release is skipped
    cycle();
    for (int i = 0; i < 4; i++) begin
      dval = 1'b1; data = 12'h800;
      cycle();
      check_eq("skip_red", 32'(red), 32'h800);
      check_eq("skip_busy", 32'(busy), 0);
    end
    fval = 1'b0; dval = 1'b0;
    cycle();
    check_eq("skip_cv", 32'(count_valid), 0);
    idle_check(1, 0);

    // Next full frame of the same data counts
    for (int i = 0; i < 4; i++) begin pix_buf[i] = 12'h800; exp_buf[i] = 12'h800; end
    send_frame(4, 4, 1'b0, 99, 12'h000);
    idle_check(2, 4);

    // Binarized frame; pixel on the falling-edge cycle is not counted
    binarize = 1'b1; thr = 12'h400;
    pix_buf[0] = 12'h000; pix_buf[1] = 12'h3FF; pix_buf[2] = 12'h400; pix_buf[3] = 12'h401;
    pix_buf[4] = 12'hFFF; pix_buf[5] = 12'h100; pix_buf[6] = 12'h400; pix_buf[7] = 12'h000;
    exp_buf[0] = 12'h000; exp_buf[1] = 12'h000; exp_buf[2] = 12'hFFF; exp_buf[3] = 12'hFFF;
    exp_buf[4] = 12'hFFF; exp_buf[5] = 12'h000; exp_buf[6] = 12'hFFF; exp_buf[7] = 12'h000;
    send_frame(8, 4, 1'b1, 99, 12'h000);
    idle_check(2, 4);

    // Threshold change mid-frame, then a back-to-back frame using the new one
    thr = 12'h400;
    pix_buf[0] = 12'h500; pix_buf[1] = 12'h500; pix_buf[2] = 12'hF00; pix_buf[3] = 12'hF80;
    for (int i = 0; i < 4; i++) exp_buf[i] = 12'hFFF;
    send_frame(4, 4, 1'b0, 2, 12'hF00);
    exp_buf[0] = 12'h000; exp_buf[1] = 12'h000; exp_buf[2] = 12'hFFF; exp_buf[3] = 12'hFFF;
    send_frame(4, 2, 1'b0, 99, 12'h000);
    idle_check(2, 2);

    // Threshold 0: every pixel is an edge
    thr = 12'h000;
    pix_buf[0] = 12'h000; pix_buf[1] = 12'h001; pix_buf[2] = 12'hFFF;
    for (int i = 0; i < 3; i++) exp_buf[i] = 12'hFFF;
    send_frame(3, 3, 1'b0, 99, 12'h000);
    idle_check(1, 3);

    // Threshold 0xFFF: only 0xFFF is an edge
    thr = 12'hFFF;
    pix_buf[0] = 12'h000; pix_buf[1] = 12'hFFE; pix_buf[2] = 12'hFFF;
    exp_buf[0] = 12'h000; exp_buf[1] = 12'h000; exp_buf[2] = 12'hFFF;
    send_frame(3, 1, 1'b0, 99, 12'h000);
    idle_check(1, 1);

    // 20 edge pixels: 22-bit counter reads 20, 4-bit counter saturates at 15
    binarize = 1'b0; thr = 12'h400;
    for (int i = 0; i < 20; i++) begin pix_buf[i] = 12'hFFF; exp_buf[i] = 12'hFFF; end
    send_frame(20, 20, 1'b0, 99, 12'h000);
    check_eq("sat_small_hold", 32'(s_edge_count), 15);
    idle_check(1, 20);

    // Peak frame (max 0xABC), then an all-zero frame
    pix_buf[0] = 12'h100; pix_buf[1] = 12'hABC; pix_buf[2] = 12'h005; pix_buf[3] = 12'hAB0;
    for (int i = 0; i < 4; i++) exp_buf[i] = pix_buf[i];
    send_frame(4, 2, 1'b1, 99, 12'h000);
`ifdef EDGE_PEAK_EN
    check_eq("peak_abc", 32'(peak), 32'hABC);
`endif
    idle_check(1, 2);
    for (int i = 0; i < 4; i++) begin pix_buf[i] = 12'h000; exp_buf[i] = 12'h000; end
    send_frame(4, 0, 1'b0, 99, 12'h000);
    idle_check(1, 0);

    // Pixel path outside a frame uses the live threshold
    binarize = 1'b1; thr = 12'h200;
    dval = 1'b1; data = 12'h1FF;
    cycle();
    check_eq("out_lo", 32'(red), 0);
    check_eq("out_dval", 32'(odval), 1);
    data = 12'h200;
    cycle();
    check_eq("out_hi", 32'(red), 32'hFFF);
    binarize = 1'b0; data = 12'h123;
    cycle();
    check_eq("out_pass", 32'(red), 32'h123);
    dval = 1'b0;
    cycle();
    check_eq("out_dval_lo", 32'(odval), 0);
    check_eq("out_busy", 32'(busy), 0);

    // Count a frame, then reset mid-way through the next one
    thr = 12'h400;
    for (int i = 0; i < 3; i++) begin pix_buf[i] = 12'hFFF; exp_buf[i] = 12'hFFF; end
    send_frame(3, 3, 1'b0, 99, 12'h000);
    idle_check(1, 3);
    fval = 1'b1;
    cycle();
    dval = 1'b1; data = 12'hFFF;
    cycle(); cycle();
    check_eq("mid_busy_pre", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", 32'(edge_count), 0);
    check_eq("mid_rst_cv", 32'(count_valid), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_dval", 32'(odval), 0);
    @(posedge clk);
    #1;
    fval = 1'b0; dval = 1'b0;
    rst_n = 1'b1;
    idle_check(2, 0);
    for (int i = 0; i < 2; i++) begin pix_buf[i] = 12'h800; exp_buf[i] = 12'h800; end
    send_frame(2, 2, 1'b0, 99, 12'h000);
    idle_check(1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
